rotfpga_scan_loader: RTL and testbench

Host-side driver for the rotfpga scan chain. It takes configuration words over a valid/ready stream and serializes them LSB-first onto the chain input (sc) while asserting scan enable (se). Each bit it shifts out pushes one old chain bit onto the chain output, and the block captures those bits into readback words on a second valid/ready stream. It sits between a host/config controller and the uio se/sc/out_sc pins of tt_um_htfab_rotfpga2_ff, and shares its clock.

---
 rtl/rotfpga_scan_loader.sv | 160 ++++++++++++++++
 tb/tb_rotfpga_scan_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotfpga_scan_loader.sv
// Host-side scan-chain loader for rotfpga: shifts config words into the chain LSB-first and captures the displaced bits as readback words.
// Optional CRC-8 over the captured bits is enabled with `define ROTFPGA_SCAN_CRC_EN.
module rotfpga_scan_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              scan_se,
  output logic              scan_sc,
  input  logic              scan_so,
  output logic [7:0]        crc_out
);

  localparam int NUM_WORDS  = CHAIN_LEN / WORD_W;
  localparam int BIT_CNT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WORD_CNT_W = $clog2(NUM_WORDS) + 1;
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(WORD_W - 1);
  localparam logic [WORD_CNT_W-1:0] ALL_WORDS = WORD_CNT_W'(NUM_WORDS);

  generate
    if ((WORD_W < 2) || (CHAIN_LEN < WORD_W) || (CHAIN_LEN % WORD_W != 0)) begin : g_bad_geometry
      $error("rotfpga_scan_loader: CHAIN_LEN must be a non-zero multiple of WORD_W (WORD_W >= 2)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [WORD_W-1:0]       tx_q, tx_d;
  logic [WORD_W-1:0]       rx_q, rx_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0]       m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    scan_sc_q, scan_sc_d;
  logic                    done_q, done_d;
  logic                    s_ready_c;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q && !m_ready;
    scan_sc_d  = scan_sc_q;
    done_d     = 1'b0;
    s_ready_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          word_cnt_d = '0;
        end
      end
      FETCH: begin
        // Only take a word once the capture slot is guaranteed free for its readback.
        s_ready_c = !m_valid_q || m_ready;
        if (s_valid && s_ready_c) begin
          scan_sc_d = s_data[0];
          tx_d      = s_data >> 1;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        rx_d = {scan_so, rx_q[WORD_W-1:1]};
        if (bit_cnt_q == LAST_BIT) begin
          m_data_d   = rx_d;
          m_valid_d  = 1'b1;
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = (word_cnt_d == ALL_WORDS) ? FLUSH : FETCH;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          scan_sc_d = tx_q[0];
          tx_d      = tx_q >> 1;
        end
      end
      FLUSH: begin
        if (!m_valid_q || m_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      scan_sc_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      scan_sc_q  <= scan_sc_d;
      done_q     <= done_d;
    end
  end

  assign s_ready = s_ready_c;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign scan_se = (state_q == SHIFT);
  assign scan_sc = scan_sc_q;

`ifdef ROTFPGA_SCAN_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       crc_fb;

  // CRC-8 (poly 0x07) over captured bits; frozen outside SHIFT so it holds from done to the next start.
  always_comb begin
    crc_d  = crc_q;
    crc_fb = crc_q[7] ^ scan_so;
    if (state_q == IDLE && start) begin
      crc_d = 8'h00;
    end else if (state_q == SHIFT) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= 8'h00;
    else     crc_q <= crc_d;
  end

  assign crc_out = crc_q;
`else
  assign crc_out = 8'h00;
`endif

endmodule

// File: tb/tb_rotfpga_scan_loader.sv
// Self-checking bench for rotfpga_scan_loader with a behavioural 16-bit scan chain and a word-level reference model.
// Expected readback is the preloaded chain sliced into words; expected final chain is the sent words concatenated.
module tb_rotfpga_scan_loader;
  localparam int W       = 8;
  localparam int N       = 16;
  localparam int NW      = N / W;
  localparam int MAX_CYC = 400;

  logic         clk = 1'b0;
  logic         rst, start, s_valid, m_ready;
  logic [W-1:0] s_data;
  logic         s_ready, m_valid, busy, done, scan_se, scan_sc, scan_so;
  logic [W-1:0] m_data;
  logic [7:0]   crc_out;

  logic [N-1:0] chain;
  logic [N-1:0] chain_val;
  logic         chain_load;
  logic         mon_clr;

  int           se_cnt, run_len, done_cnt;
  int           run_lens[$];
  logic [W-1:0] rxq[$];
  int           total = 0;
  int           bad = 0;

  rotfpga_scan_loader #(.WORD_W(W), .CHAIN_LEN(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done),
    .scan_se (scan_se),
    .scan_sc (scan_sc),
    .scan_so (scan_so),
    .crc_out (crc_out)
  );

  always #5 clk = ~clk;

  // Scan chain model: so = chain[0]; shift toward bit 0 with sc entering at the top.
  assign scan_so = chain[0];
  always @(posedge clk) begin
    if (chain_load)   chain <= chain_val;
    else if (scan_se) chain <= {scan_sc, chain[N-1:1]};
  end

  // Monitor sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (mon_clr) begin
      se_cnt   <= 0;
      run_len  <= 0;
      done_cnt <= 0;
      run_lens.delete();
      rxq.delete();
    end else begin
      if (scan_se) begin
        se_cnt  <= se_cnt + 1;
        run_len <= run_len + 1;
      end else if (run_len != 0) begin
        run_lens.push_back(run_len);
        run_len <= 0;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (m_valid && m_ready) rxq.push_back(m_data);
    end
  end

  function automatic logic [7:0] crc_model(input logic [N-1:0] bits);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < N; i++) begin
      fb = c[7] ^ bits[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [7:0] crc_expect(input logic [N-1:0] bits);
`ifdef ROTFPGA_SCAN_CRC_EN
    return crc_model(bits);
`else
    return (bits == bits) ? 8'h00 : 8'hFF;
`endif
  endfunction

  task automatic do_pass(input string tag, input logic [N-1:0] init, input logic [W-1:0] w0,
                         input logic [W-1:0] w1, input int gap, input bit rnd, input bit bp,
                         input bit start_end);
    logic [W-1:0] words[NW];
    int           sent, cyc, gap_left, bp_left, rs;
    bit           bp_started;
    logic [W-1:0] exp_rx;
    words[0] = w0;
    words[1] = w1;
    sent = 0; cyc = 0; gap_left = 0; bp_left = 0; rs = 0; bp_started = 0;

    @(posedge clk); #1;
    chain_load = 1'b1; chain_val = init; mon_clr = 1'b1;
    @(posedge clk); #1;
    chain_load = 1'b0; mon_clr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    while (done_cnt == 0 && cyc < MAX_CYC) begin
      cyc++;
      if (bp && !bp_started && m_valid) begin
        bp_started = 1'b1;
        bp_left    = 10;
      end
      m_ready = (bp_left > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (sent < NW && gap_left == 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
        s_valid = 1'b1;
        s_data  = words[sent];
      end else begin
        s_valid = 1'b0;
        s_data  = W'($urandom);
      end
      start = start_end && (se_cnt == N) && !done && (done_cnt == 0);

      @(negedge clk);
      if (bp_left > 0) begin
        total++;
        if ({s_ready, scan_se, m_data} !== {1'b0, 1'b0, init[W-1:0]}) begin
          bad++;
          $display("FAIL %s backpressure hold: s_ready/scan_se/m_data got %b/%b/%h want 0/0/%h",
                   tag, s_ready, scan_se, m_data, init[W-1:0]);
        end
        bp_left--;
        if (bp_left == 0) rs = 1;
      end else if (rs == 1) begin
        total++;
        if (s_ready !== 1'b1) begin
          bad++;
          $display("FAIL %s resume accept: s_ready got %b want 1", tag, s_ready);
        end
        rs = 2;
      end else if (rs == 2) begin
        total++;
        if (scan_se !== 1'b1) begin
          bad++;
          $display("FAIL %s resume shift: scan_se got %b want 1", tag, scan_se);
        end
        rs = 0;
      end
      if (s_valid && s_ready) begin
        sent++;
        gap_left = gap;
      end else if (gap_left > 0 && !scan_se && busy) begin
        gap_left--;
      end
      @(posedge clk); #1;
    end

    s_valid = 1'b0; start = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL %s done pulses: got %0d want 1 (cycles %0d)", tag, done_cnt, cyc);
    end
    total++;
    if (se_cnt !== N) begin
      bad++;
      $display("FAIL %s scan_se high cycles: got %0d want %0d", tag, se_cnt, N);
    end
    total++;
    if (run_lens.size() !== NW) begin
      bad++;
      $display("FAIL %s scan_se runs: got %0d want %0d", tag, run_lens.size(), NW);
    end
    foreach (run_lens[i]) begin
      total++;
      if (run_lens[i] !== W) begin
        bad++;
        $display("FAIL %s run[%0d] length: got %0d want %0d", tag, i, run_lens[i], W);
      end
    end
    total++;
    if (rxq.size() !== NW) begin
      bad++;
      $display("FAIL %s readback count: got %0d want %0d", tag, rxq.size(), NW);
    end
    foreach (rxq[i]) begin
      exp_rx = (i < NW) ? init[i*W +: W] : 'x;
      total++;
      if (rxq[i] !== exp_rx) begin
        bad++;
        $display("FAIL %s readback[%0d]: got %h want %h", tag, i, rxq[i], exp_rx);
      end
    end
    total++;
    if (chain !== {w1, w0}) begin
      bad++;
      $display("FAIL %s final chain: got %h want %h", tag, chain, {w1, w0});
    end
    total++;
    if (crc_out !== crc_expect(init)) begin
      bad++;
      $display("FAIL %s crc_out: got %h want %h", tag, crc_out, crc_expect(init));
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy after pass: got %b want 0", tag, busy);
    end
    if (done_cnt == 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({s_ready, m_valid, m_data, busy, done, scan_se, scan_sc, crc_out} !== '0) begin
      bad++;
      $display("FAIL reset outputs: s_ready=%b m_valid=%b m_data=%h busy=%b done=%b se=%b sc=%b crc=%h want all 0",
               s_ready, m_valid, m_data, busy, done, scan_se, scan_sc, crc_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({busy, scan_se, s_ready} !== 3'b000) begin
        bad++;
        $display("FAIL idle cycle %0d: busy/se/s_ready got %b%b%b want 000", i, busy, scan_se, s_ready);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
  endtask

  task automatic test_basic;
    do_pass("basic", 16'h1234, 8'hA5, 8'h3C, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_input_stall;
    do_pass("input_stall", 16'h1234, 8'hA5, 8'h3C, 5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    do_pass("backpressure", 16'h1234, 8'hA5, 8'h3C, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_abort;
    int waited;
    @(posedge clk); #1;
    chain_load = 1'b1; chain_val = 16'h1234; mon_clr = 1'b1;
    @(posedge clk); #1;
    chain_load = 1'b0; mon_clr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
    waited = 0;
    while (scan_se !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    s_valid = 1'b0;
    total++;
    if (scan_se !== 1'b1) begin
      bad++;
      $display("FAIL abort shift start: scan_se got %b want 1 within 50 cycles", scan_se);
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, scan_se} !== 2'b11) begin
      bad++;
      $display("FAIL abort start ignored: busy/se got %b%b want 11", busy, scan_se);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({scan_se, busy, m_valid, done} !== 4'b0000) begin
      bad++;
      $display("FAIL abort reset: se/busy/m_valid/done got %b%b%b%b want 0000", scan_se, busy, m_valid, done);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== 0) begin
      bad++;
      $display("FAIL abort done pulses: got %0d want 0", done_cnt);
    end
    do_pass("abort_rerun", 16'h1234, 8'hA5, 8'h3C, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_crc;
    logic [7:0] want;
`ifdef ROTFPGA_SCAN_CRC_EN
    want = 8'hB6;
`else
    want = 8'h00;
`endif
    do_pass("crc", 16'h0001, W'($urandom), W'($urandom), 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (crc_out !== want) begin
      bad++;
      $display("FAIL crc known vector: got %h want %h", crc_out, want);
    end
  endtask

  task automatic test_random;
    for (int p = 0; p < 6; p++) begin
      do_pass($sformatf("random%0d", p), N'($urandom), W'($urandom), W'($urandom),
              $urandom_range(0, 3), 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    chain_load = 1'b0; chain_val = '0; mon_clr = 1'b1;
    test_reset;
    mon_clr = 1'b0;
    test_basic;
    test_input_stall;
    test_backpressure;
    test_abort;
    test_crc;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
